barker_frame_sync: RTL and testbench
====================================

BARKER_FRAME_SYNC -- requirements
Module: barker_frame_sync

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64: accepted beats between consecutive Barker peaks; legal range 14..65535.
REQ-002 SHALL have parameter CONFIRM_N, default 3: consecutive on-grid peaks required to lock; legal range 2..15.
REQ-003 SHALL have parameter MISS_MAX, default 2: consecutive missed peaks that drop lock; legal range 1..15.
REQ-004 i_clk  in  1  sole clock; all logic rising-edge.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_enable  in  1  synchronous run enable.
REQ-007 s_tvalid  in  1  correlator output beat valid.
REQ-008 s_tuser  in  1  correlator peak flag for the beat.
REQ-009 s_tready  out  1  beat accept.
REQ-010 o_locked  out  1  high while in LOCKED.
REQ-011 o_frame_start  out  1  one-cycle frame-boundary strobe.
REQ-012 o_state  out  2  encoded state: SEARCH=0, VERIFY=1, LOCKED=2.
REQ-013 o_frame_cnt  out  16  count of o_frame_start strobes, wraps modulo 2^16.

Function
REQ-014 SHALL drive s_tready=1 whenever i_rst_n=1, i.e. never stall the correlator; beat = s_tvalid&s_tready.
REQ-015 SHALL evaluate state, counters and s_tuser only on beats; non-beat cycles change nothing except the i_enable response.
REQ-016 SHALL keep position counter d (16 bit) = beats since last anchor; d=0 on the anchor beat; expected peak at d=FRAME_LEN, where d reloads to 0.
REQ-017 SEARCH: a beat with s_tuser=1 -> VERIFY, d=0, confirm=1; otherwise stay.
REQ-018 VERIFY: s_tuser=1 at d=FRAME_LEN -> confirm+1, d=0; if confirm reaches CONFIRM_N -> LOCKED with o_frame_start on that beat.
REQ-019 VERIFY: s_tuser=1 at 0<d<FRAME_LEN -> re-anchor (d=0, confirm=1, stay VERIFY).
REQ-020 VERIFY: s_tuser=0 at d=FRAME_LEN -> SEARCH, confirm=0.
REQ-021 LOCKED (flywheel): at d=FRAME_LEN, o_frame_start=1 and d=0 whether or not a peak is present; peak -> miss=0; no peak -> miss+1.
REQ-022 LOCKED: when miss reaches MISS_MAX -> SEARCH on that beat, o_frame_start suppressed on that beat, miss=0.
REQ-023 LOCKED: s_tuser=1 at d!=FRAME_LEN SHALL be ignored.
REQ-024 o_frame_start SHALL be registered, asserted in the cycle after the qualifying beat, width exactly one cycle.
REQ-025 o_frame_cnt SHALL increment with every o_frame_start, wrap 65535->0, clear only on reset.
REQ-026 i_enable=0 SHALL force SEARCH, d=0, confirm=0, miss=0 next cycle, suppress o_frame_start, and override a simultaneous beat.
REQ-027 o_state, o_locked SHALL be registered, updated in the cycle after the transition beat.

Reset
REQ-028 i_rst_n=0 SHALL immediately set state=SEARCH, d=0, confirm=0, miss=0, o_frame_start=0, o_locked=0, o_state=0, o_frame_cnt=0, s_tready=0.
REQ-029 Reset mid-frame SHALL discard all lock history; after release, sync restarts from SEARCH.

Structure
REQ-030 State enum sync_state_t (2 bit) and the SEARCH/VERIFY/LOCKED encodings SHALL reside in the shared package included through utils.svh.
REQ-031 Single module, one FSM plus counters, no sub-module; instantiated behind the correlator's m_axis (tuser carries the peak flag).

Verification (FRAME_LEN=16, CONFIRM_N=3, MISS_MAX=2, s_tvalid=1 continuous unless stated)
REQ-032 Peaks at beats 5,21,37 -> VERIFY after 5, LOCKED and o_frame_start after 37, o_frame_cnt=1.
REQ-033 Locked, then peaks removed -> o_frame_start at the next expected beat (miss=1), SEARCH at the one after that with no strobe, o_locked=0.
REQ-034 Peaks at 5 and 13, then 29, 45 -> re-anchor at 13; lock after 45.
REQ-035 Locked, s_tvalid toggling 50% -> strobes every 16 accepted beats, spurious peak at d=7 ignored.
REQ-036 Locked, i_enable=0 one cycle coincident with an expected peak beat -> no strobe, SEARCH; async reset mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/barker_frame_sync_pkg.sv
// Shared types for the Barker frame synchroniser: FSM state encoding and counter widths.
package barker_frame_sync_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    localparam int POS_W = 16;
    localparam int CNT_W = 16;
    localparam int HIST_W = 4;

endpackage

// File: rtl/barker_frame_sync_if.sv
// Beat stream from the correlator's m_axis; tuser carries the per-beat peak flag.
interface barker_frame_sync_if;

    logic s_tvalid;
    logic s_tuser;
    logic s_tready;

    modport master (
        output s_tvalid,
        output s_tuser,
        input  s_tready
    );

    modport slave (
        input  s_tvalid,
        input  s_tuser,
        output s_tready
    );

endinterface

// File: rtl/barker_frame_sync.sv
// Frame synchroniser: confirms a regular grid of Barker peaks, then flywheels frame strobes
// across missed peaks until too many are lost in a row.
module barker_frame_sync
    import barker_frame_sync_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int CONFIRM_N = 3,
    parameter int MISS_MAX  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    barker_frame_sync_if.slave     s_axis,
    output logic                   o_locked,
    output logic                   o_frame_start,
    output logic [1:0]             o_state,
    output logic [CNT_W-1:0]       o_frame_cnt
);

    sync_state_t        state;
    logic [POS_W-1:0]   d;
    logic [HIST_W-1:0]  confirm;
    logic [HIST_W-1:0]  miss;
    logic [POS_W-1:0]   pos;
    logic               beat;
    logic               peak;
    logic               at_expected;

    // The correlator is never stalled; only reset withdraws ready.
    assign s_axis.s_tready = i_rst_n;

    assign beat        = s_axis.s_tvalid & s_axis.s_tready;
    assign peak        = s_axis.s_tuser;
    assign pos         = d + POS_W'(1);
    assign at_expected = (pos == POS_W'(FRAME_LEN));
    assign o_state     = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= SEARCH;
            d             <= '0;
            confirm       <= '0;
            miss          <= '0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= '0;
        end else if (!i_enable) begin
            state         <= SEARCH;
            d             <= '0;
            confirm       <= '0;
            miss          <= '0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            if (beat) begin
                unique case (state)
                    SEARCH: begin
                        if (peak) begin
                            state   <= VERIFY;
                            d       <= '0;
                            confirm <= HIST_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (at_expected) begin
                            d <= '0;
                            if (!peak) begin
                                state   <= SEARCH;
                                confirm <= '0;
                            end else if (confirm == HIST_W'(CONFIRM_N - 1)) begin
                                state         <= LOCKED;
                                confirm       <= '0;
                                miss          <= '0;
                                o_locked      <= 1'b1;
                                o_frame_start <= 1'b1;
                                o_frame_cnt   <= o_frame_cnt + CNT_W'(1);
                            end else begin
                                confirm <= confirm + HIST_W'(1);
                            end
                        end else if (peak) begin
                            d       <= '0;
                            confirm <= HIST_W'(1);
                        end else begin
                            d <= pos;
                        end
                    end
                    LOCKED: begin
                        // Off-grid peaks are ignored; the flywheel only looks at the expected slot.
                        if (at_expected) begin
                            d <= '0;
                            if (peak) begin
                                miss          <= '0;
                                o_frame_start <= 1'b1;
                                o_frame_cnt   <= o_frame_cnt + CNT_W'(1);
                            end else if (miss == HIST_W'(MISS_MAX - 1)) begin
                                state    <= SEARCH;
                                miss     <= '0;
                                o_locked <= 1'b0;
                            end else begin
                                miss          <= miss + HIST_W'(1);
                                o_frame_start <= 1'b1;
                                o_frame_cnt   <= o_frame_cnt + CNT_W'(1);
                            end
                        end else begin
                            d <= pos;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        d        <= '0;
                        confirm  <= '0;
                        miss     <= '0;
                        o_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_barker_frame_sync.sv
// Scoreboard bench for barker_frame_sync: directed sync scenarios plus a randomised
// noisy peak stream, checked against an absolute-beat-index reference model.
module tb_barker_frame_sync;

    localparam int FL = 16;
    localparam int CN = 3;
    localparam int MM = 2;

    typedef struct {
        int state;
        int locked;
        int fs;
        int cnt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        o_locked;
    logic        o_frame_start;
    logic [1:0]  o_state;
    logic [15:0] o_frame_cnt;

    barker_frame_sync_if bus ();

    barker_frame_sync #(
        .FRAME_LEN (FL),
        .CONFIRM_N (CN),
        .MISS_MAX  (MM)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .s_axis        (bus),
        .o_locked      (o_locked),
        .o_frame_start (o_frame_start),
        .o_state       (o_state),
        .o_frame_cnt   (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Reference model: peaks are judged by absolute accepted-beat index relative to the anchor.
    int     m_mode;
    longint m_beat_idx;
    longint m_anchor;
    int     m_confirm;
    int     m_miss;
    int     m_cnt;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_mode = 0;
        m_beat_idx = 0;
        m_anchor = 0;
        m_confirm = 0;
        m_miss = 0;
        m_cnt = 0;
    endtask

    task automatic modelStep(input bit en, input bit valid, input bit user, output int strobe);
        longint since;
        strobe = 0;
        if (!en) begin
            m_mode = 0;
            m_confirm = 0;
            m_miss = 0;
        end else if (valid) begin
            m_beat_idx++;
            since = m_beat_idx - m_anchor;
            if (m_mode == 0) begin
                if (user) begin
                    m_mode = 1;
                    m_anchor = m_beat_idx;
                    m_confirm = 1;
                end
            end else if (m_mode == 1) begin
                if (since == FL) begin
                    m_anchor = m_beat_idx;
                    if (user) begin
                        m_confirm++;
                        if (m_confirm == CN) begin
                            m_mode = 2;
                            m_miss = 0;
                            strobe = 1;
                        end
                    end else begin
                        m_mode = 0;
                        m_confirm = 0;
                    end
                end else if (user) begin
                    m_anchor = m_beat_idx;
                    m_confirm = 1;
                end
            end else begin
                if (since == FL) begin
                    m_anchor = m_beat_idx;
                    if (user) m_miss = 0;
                    else      m_miss++;
                    if (m_miss == MM) begin
                        m_mode = 0;
                        m_miss = 0;
                    end else begin
                        strobe = 1;
                    end
                end
            end
        end
        if (strobe != 0) m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic applyStimulus(input bit en, input bit valid, input bit user);
        int   strobe;
        exp_t e;
        @(negedge clk);
        enable = en;
        bus.s_tvalid = valid;
        bus.s_tuser = user;
        modelStep(en, valid, user, strobe);
        e.state = m_mode;
        e.locked = (m_mode == 2) ? 1 : 0;
        e.fs = strobe;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic runBeats(input int count, input logic [127:0] mask);
        for (int i = 0; i < count; i++) applyStimulus(1'b1, 1'b1, mask[i]);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"}, int'(o_state), 0);
        checkOutput({tag, "_locked"}, int'(o_locked), 0);
        checkOutput({tag, "_fs"}, int'(o_frame_start), 0);
        checkOutput({tag, "_cnt"}, int'(o_frame_cnt), 0);
        checkOutput({tag, "_tready"}, int'(bus.s_tready), 0);
    endtask

    task automatic randomRun(input int cycles);
        int gen_k = 0;
        int phase = int'($urandom_range(FL - 1));
        bit en, valid, user;
        for (int c = 0; c < cycles; c++) begin
            if (c % 500 == 499) phase = int'($urandom_range(FL - 1));
            en = ($urandom_range(199) != 0);
            valid = ($urandom_range(3) != 0);
            user = 1'b0;
            if (valid) begin
                if (gen_k % FL == phase) user = ($urandom_range(7) != 0);
                else                     user = ($urandom_range(31) == 0);
                gen_k++;
            end else begin
                user = ($urandom_range(1) != 0);
            end
            applyStimulus(en, valid, user);
        end
    endtask

    // Monitor: every cycle that had stimulus queued is compared one step after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("sb_state", int'(o_state), e.state);
            checkOutput("sb_locked", int'(o_locked), e.locked);
            checkOutput("sb_frame_start", int'(o_frame_start), e.fs);
            checkOutput("sb_frame_cnt", int'(o_frame_cnt), e.cnt);
            checkOutput("sb_tready", int'(bus.s_tready), 1);
        end
    end

    initial begin
        logic [127:0] mask;

        rst_n = 1'b0;
        enable = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tuser = 1'b0;
        modelReset();
        #23;
        checkReset("reset");

        @(negedge clk);
        enable = 1'b1;
        rst_n = 1'b1;

        $display("[TB] lock on peaks 5,21,37");
        mask = '0;
        mask[5] = 1'b1;
        mask[21] = 1'b1;
        mask[37] = 1'b1;
        runBeats(38, mask);
        @(posedge clk); #1;
        checkOutput("lock_locked", int'(o_locked), 1);
        checkOutput("lock_fs", int'(o_frame_start), 1);
        checkOutput("lock_cnt", int'(o_frame_cnt), 1);

        $display("[TB] peaks removed, flywheel then drop");
        runBeats(33, '0);
        @(posedge clk); #1;
        checkOutput("drop_locked", int'(o_locked), 0);
        checkOutput("drop_state", int'(o_state), 0);
        checkOutput("drop_cnt", int'(o_frame_cnt), 2);

        $display("[TB] re-anchor at 13");
        mask = '0;
        mask[5] = 1'b1;
        mask[13] = 1'b1;
        mask[29] = 1'b1;
        mask[45] = 1'b1;
        runBeats(46, mask);
        @(posedge clk); #1;
        checkOutput("reanchor_locked", int'(o_locked), 1);
        checkOutput("reanchor_cnt", int'(o_frame_cnt), 3);

        $display("[TB] locked with gapped valid and spurious peaks");
        begin
            int k = 0;
            for (int c = 0; c < 128; c++) begin
                if (c % 2 == 1) begin
                    applyStimulus(1'b1, 1'b1, (k % FL == FL - 1) || (k % FL == 6));
                    k++;
                end else begin
                    applyStimulus(1'b1, 1'b0, 1'b1);
                end
            end
        end
        @(posedge clk); #1;
        checkOutput("gapped_fs", int'(o_frame_start), 1);
        checkOutput("gapped_cnt", int'(o_frame_cnt), 7);

        $display("[TB] enable drop on expected beat");
        runBeats(15, '0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        checkOutput("disable_state", int'(o_state), 0);
        checkOutput("disable_fs", int'(o_frame_start), 0);
        checkOutput("disable_cnt", int'(o_frame_cnt), 7);

        $display("[TB] randomised stream");
        randomRun(3000);

        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        modelReset();
        enable = 1'b1;
        bus.s_tvalid = 1'b0;
        bus.s_tuser = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        randomRun(1500);

        @(posedge clk); #2;
        checkOutput("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
